music_rom_player: RTL and testbench



---
 rtl/music_rom_player.sv | 189 ++++++++++++++++++
 tb/tb_music_rom_player.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/music_rom_player.sv
// music_rom_player: multi-song note-ROM player with programmable tempo,
// pause/resume, stop and loop. Each song occupies a fixed SLOT_DEPTH-word
// slot. An all-ones word, or the end of the slot, ends the song.
// Optional feature macro: ARTICULATION_GAP_EN. When it is defined, data_out is
// silenced at the tail of a slot whose next word repeats the current note.
module music_rom_player #(
  parameter int    DATA_WIDTH = 10,
  parameter int    SLOT_DEPTH = 256,
  parameter int    SONG_COUNT = 4,
  parameter int    TICK_WIDTH = 26,
  parameter string INIT_FILE  = "songs.mem",
  parameter int    GAP_TICKS  = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(SONG_COUNT)-1:0] song_sel,
  input  logic [TICK_WIDTH-1:0]         tick_interval,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          stop,
  input  logic                          loop_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(SLOT_DEPTH)-1:0] position
);

  localparam int SONG_W = $clog2(SONG_COUNT);
  localparam int PTR_W  = $clog2(SLOT_DEPTH);
  localparam logic [DATA_WIDTH-1:0] END_CODE = '1;
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(SLOT_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_PAUSE} state_t;

  logic [DATA_WIDTH-1:0] rom_mem [0:SONG_COUNT*SLOT_DEPTH-1];

  state_t                state_q, resume_q;
  logic [SONG_W-1:0]     song_q, song_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [TICK_WIDTH-1:0] interval_q, counter_q;
  logic [DATA_WIDTH-1:0] data_q, rd_data_q;
  logic                  valid_q, valid_save_q, busy_q, done_q;
  logic                  end_q;  // slot ran out at the last word: implicit end
  logic                  tick_last, load_end, empty_song;

  assign tick_last  = (counter_q == interval_q - TICK_WIDTH'(1));
  assign load_end   = end_q || (rd_data_q == END_CODE);
  assign empty_song = (rd_data_q == END_CODE) && (ptr_q == '0) && !end_q;

  // Next song/pointer; the ROM is addressed with these so LOAD sees its word after one clock.
  always_comb begin
    song_d = song_q;
    ptr_d  = ptr_q;
    if (!stop) begin
      if (start) begin
        song_d = song_sel;
        ptr_d  = '0;
      end else if (state_q == S_LOAD && !pause && load_end && !empty_song && loop_en) begin
        ptr_d = '0;
      end else if (state_q == S_PLAY && !pause && tick_last && ptr_q != LAST_PTR) begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end
  end

  // Synchronous ROM read port (current word).
  always_ff @(posedge clk) begin
    rd_data_q <= rom_mem[{song_d, ptr_d}];
  end

  // Player FSM: stop > start > pause > tick advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      resume_q     <= S_IDLE;
      song_q       <= '0;
      ptr_q        <= '0;
      interval_q   <= TICK_WIDTH'(1);
      counter_q    <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      valid_save_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      end_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      song_q <= song_d;
      ptr_q  <= ptr_d;
      if (stop) begin
        state_q   <= S_IDLE;
        data_q    <= '0;
        valid_q   <= 1'b0;
        busy_q    <= 1'b0;
        counter_q <= '0;
        end_q     <= 1'b0;
      end else if (start) begin
        state_q    <= S_LOAD;
        interval_q <= (tick_interval == '0) ? TICK_WIDTH'(1) : tick_interval;
        counter_q  <= '0;
        data_q     <= '0;
        valid_q    <= 1'b0;
        busy_q     <= 1'b1;
        end_q      <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (pause) begin
              resume_q     <= S_LOAD;
              valid_save_q <= valid_q;
              valid_q      <= 1'b0;
              state_q      <= S_PAUSE;
            end else if (load_end && (empty_song || !loop_en)) begin
              done_q  <= 1'b1;
              data_q  <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              end_q   <= 1'b0;
              state_q <= S_IDLE;
            end else if (load_end) begin
              // Loop: stay in LOAD while word 0 is fetched again.
              end_q <= 1'b0;
            end else begin
              data_q    <= rd_data_q;
              valid_q   <= 1'b1;
              counter_q <= '0;
              state_q   <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (pause) begin
              resume_q     <= S_PLAY;
              valid_save_q <= 1'b1;
              valid_q      <= 1'b0;
              state_q      <= S_PAUSE;
            end else if (tick_last) begin
              counter_q <= '0;
              end_q     <= (ptr_q == LAST_PTR);
              state_q   <= S_LOAD;
            end else begin
              counter_q <= counter_q + TICK_WIDTH'(1);
            end
          end
          S_PAUSE: begin
            if (!pause) begin
              state_q <= resume_q;
              valid_q <= valid_save_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_valid = valid_q;
  assign busy       = busy_q;   // covers LOAD too so busy never blinks between words
  assign done       = done_q;
  assign position   = ptr_q;

`ifdef ARTICULATION_GAP_EN
  logic [DATA_WIDTH-1:0] next_word_q;
  logic [63:0]           gap_w, ival_w, cnt_w;
  logic                  gap_active;

  // Second read port: the word after the one currently addressed.
  always_ff @(posedge clk) begin
    next_word_q <= rom_mem[{song_d, ptr_d + PTR_W'(1)}];
  end

  // Silence the tail of a slot when the following word repeats this note.
  always_comb begin
    gap_w      = 64'(GAP_TICKS);
    ival_w     = 64'(interval_q);
    cnt_w      = 64'(counter_q);
    gap_active = (state_q == S_PLAY) && (ptr_q != LAST_PTR) &&
                 (next_word_q == data_q) && (gap_w < ival_w) &&
                 (cnt_w >= ival_w - gap_w);
  end

  assign data_out = gap_active ? '0 : data_q;
`else
  // GAP_TICKS only matters when the articulation gap is built in.
  localparam int gap_ticks_unused = GAP_TICKS;
  assign data_out = data_q;
`endif

endmodule

// File: tb/tb_music_rom_player.sv
// Bench for music_rom_player: per-cycle vectors with expected outputs, queued
// as a scoreboard and compared one clock later, #1 after the active edge.
module tb_music_rom_player;
  localparam int DW = 10;
  localparam int SD = 8;
  localparam int SC = 2;
  localparam int TW = 8;
`ifdef ARTICULATION_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:0]    song_sel;
  logic [TW-1:0] tick_interval;
  logic          start, pause, stop, loop_en;
  logic [DW-1:0] data_out;
  logic          data_valid, busy, done;
  logic [2:0]    position;

  always #5 clk = ~clk;

  music_rom_player #(
    .DATA_WIDTH(DW), .SLOT_DEPTH(SD), .SONG_COUNT(SC), .TICK_WIDTH(TW),
    .INIT_FILE(""), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .rst(rst), .song_sel(song_sel), .tick_interval(tick_interval),
    .start(start), .pause(pause), .stop(stop), .loop_en(loop_en),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done),
    .position(position)
  );

  typedef struct {
    bit            start, stop, pause, loop_en;
    logic [0:0]    song;
    logic [TW-1:0] ival;
    logic [DW-1:0] e_data;
    bit            e_valid, e_busy, e_done;
    logic [2:0]    e_pos;
    bit            chk_pos;
  } vec_t;

  vec_t sb_q[$];
  vec_t t_play[15];
  vec_t t_loop[19];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_vec    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(bit st, bit sp, bit pa, bit lp, bit sg, int iv,
                              int d, bit v, bit b, bit dn, int p, bit cp);
    vec_t r;
    r.start = st; r.stop = sp; r.pause = pa; r.loop_en = lp;
    r.song = sg; r.ival = TW'(iv);
    r.e_data = DW'(d); r.e_valid = v; r.e_busy = b; r.e_done = dn;
    r.e_pos = 3'(p); r.chk_pos = cp;
    return r;
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    start = v.start; stop = v.stop; pause = v.pause; loop_en = v.loop_en;
    song_sel = v.song; tick_interval = v.ival;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_vec++;
    check($sformatf("%s.data", tag),  32'(data_out),   32'(e.e_data));
    check($sformatf("%s.valid", tag), 32'(data_valid), 32'(e.e_valid));
    check($sformatf("%s.busy", tag),  32'(busy),       32'(e.e_busy));
    check($sformatf("%s.done", tag),  32'(done),       32'(e.e_done));
    if (e.chk_pos) check($sformatf("%s.pos", tag), 32'(position), 32'(e.e_pos));
    $display("vec %0d %s: data=%h valid=%b busy=%b done=%b pos=%0d",
             n_vec, tag, data_out, data_valid, busy, done, position);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int g4;
    start = 0; stop = 0; pause = 0; loop_en = 0; song_sel = '0; tick_interval = '0;
    g4 = GAP_ON ? 0 : 'h004;

    // Song 0: 004,004,040,END. Song 1 starts empty.
    for (int i = 0; i < SD*SC; i++) dut.rom_mem[i] = '0;
    dut.rom_mem[0] = 10'h004;
    dut.rom_mem[1] = 10'h004;
    dut.rom_mem[2] = 10'h040;
    dut.rom_mem[3] = 10'h3FF;
    dut.rom_mem[8] = 10'h3FF;

    // Song 0, interval 3: each word held 4 clocks, then a single done pulse.
    t_play[0]  = mk(1,0,0,0,0,3, 'h000,0,1,0, 0,1);
    t_play[1]  = mk(0,0,0,0,0,3, 'h004,1,1,0, 0,1);
    t_play[2]  = mk(0,0,0,0,0,3, 'h004,1,1,0, 0,1);
    t_play[3]  = mk(0,0,0,0,0,3, g4,   1,1,0, 0,1);
    t_play[4]  = mk(0,0,0,0,0,3, 'h004,1,1,0, 1,1);
    t_play[5]  = mk(0,0,0,0,0,3, 'h004,1,1,0, 1,1);
    t_play[6]  = mk(0,0,0,0,0,3, 'h004,1,1,0, 1,1);
    t_play[7]  = mk(0,0,0,0,0,3, 'h004,1,1,0, 1,1);
    t_play[8]  = mk(0,0,0,0,0,3, 'h004,1,1,0, 2,1);
    t_play[9]  = mk(0,0,0,0,0,3, 'h040,1,1,0, 2,1);
    t_play[10] = mk(0,0,0,0,0,3, 'h040,1,1,0, 2,1);
    t_play[11] = mk(0,0,0,0,0,3, 'h040,1,1,0, 2,1);
    t_play[12] = mk(0,0,0,0,0,3, 'h040,1,1,0, 3,1);
    t_play[13] = mk(0,0,0,0,0,3, 'h000,0,0,1, 0,0);
    t_play[14] = mk(0,0,0,0,0,3, 'h000,0,0,0, 0,0);

    // Same song with loop: END triggers a reload of word 0, no done; then stop.
    for (int i = 0; i <= 12; i++) begin
      t_loop[i] = t_play[i];
      t_loop[i].loop_en = 1'b1;
    end
    t_loop[13] = mk(0,0,0,1,0,3, 'h040,1,1,0, 0,1);
    t_loop[14] = mk(0,0,0,1,0,3, 'h004,1,1,0, 0,1);
    t_loop[15] = mk(0,0,0,1,0,3, 'h004,1,1,0, 0,1);
    t_loop[16] = mk(0,0,0,1,0,3, g4,   1,1,0, 0,1);
    t_loop[17] = mk(0,1,0,1,0,3, 'h000,0,0,0, 0,0);
    t_loop[18] = mk(0,0,0,1,0,3, 'h000,0,0,0, 0,0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset.data",  32'(data_out),   32'h0);
    check("reset.valid", 32'(data_valid), 32'h0);
    check("reset.busy",  32'(busy),       32'h0);
    check("reset.done",  32'(done),       32'h0);
    check("reset.pos",   32'(position),   32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) run_vec(t_play[i], "play");
    for (int i = 0; i < 19; i++) run_vec(t_loop[i], "loop");

    // Pause 10 clocks mid-slot: frozen, invalid; the slot then finishes normally.
    run_vec(mk(1,0,0,0,0,3, 'h004*0,0,1,0, 0,1), "pause");
    run_vec(mk(0,0,0,0,0,3, 'h004,1,1,0, 0,1), "pause");
    run_vec(mk(0,0,0,0,0,3, 'h004,1,1,0, 0,1), "pause");
    for (int i = 0; i < 10; i++) run_vec(mk(0,0,1,0,0,3, 'h004,0,1,0, 0,1), "pause");
    run_vec(mk(0,0,0,0,0,3, 'h004,1,1,0, 0,1), "pause");
    run_vec(mk(0,0,0,0,0,3, g4,   1,1,0, 0,1), "pause");
    run_vec(mk(0,0,0,0,0,3, 'h004,1,1,0, 1,1), "pause");
    run_vec(mk(0,1,0,0,0,3, 'h000,0,0,0, 0,0), "pause");

    // Empty song 1: done two clocks after start, never valid.
    run_vec(mk(1,0,0,0,1,3, 'h000,0,1,0, 0,1), "empty");
    run_vec(mk(0,0,0,0,1,3, 'h000,0,0,1, 0,0), "empty");
    run_vec(mk(0,0,0,0,1,3, 'h000,0,0,0, 0,0), "empty");

    // Song 1 fills the whole slot, interval 1: positions 0..7, implicit end.
    for (int k = 0; k < SD; k++) dut.rom_mem[SD + k] = DW'(1 << k);
    run_vec(mk(1,0,0,0,1,1, 0,0,1,0, 0,1), "full");
    for (int n = 1; n <= 16; n++) begin
      int k;
      k = (n - 1) / 2;
      if (n % 2 == 1) run_vec(mk(0,0,0,0,1,1, 1 << k,1,1,0, k,1), "full");
      else            run_vec(mk(0,0,0,0,1,1, 1 << k,1,1,0, (k < 7) ? k + 1 : 7,1), "full");
    end
    run_vec(mk(0,0,0,0,1,1, 0,0,0,1, 0,0), "full");
    run_vec(mk(0,0,0,0,1,1, 0,0,0,0, 0,0), "full");

    // tick_interval 0 behaves as 1.
    run_vec(mk(1,0,0,0,1,0, 0,    0,1,0, 0,1), "ival0");
    run_vec(mk(0,0,0,0,1,0, 'h001,1,1,0, 0,1), "ival0");
    run_vec(mk(0,0,0,0,1,0, 'h001,1,1,0, 1,1), "ival0");
    run_vec(mk(0,1,0,0,1,0, 0,    0,0,0, 0,0), "ival0");

    // start and stop together: stop wins.
    run_vec(mk(1,1,0,0,0,3, 0,0,0,0, 0,0), "startstop");
    run_vec(mk(0,0,0,0,0,3, 0,0,0,0, 0,0), "startstop");

    // Asynchronous reset in the middle of a slot.
    for (int i = 0; i <= 5; i++) run_vec(t_play[i], "arst");
    rst = 1'b1;
    #2;
    check("arst.data",  32'(data_out),   32'h0);
    check("arst.valid", 32'(data_valid), 32'h0);
    check("arst.busy",  32'(busy),       32'h0);
    check("arst.pos",   32'(position),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec(mk(0,0,0,0,0,3, 0,0,0,0, 0,1), "arst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
